mdu_iterative: RTL and testbench

- Multi-cycle multiply/divide unit in the EX stage, alongside the single-cycle ALU.
- Takes the same rs/rt operand buses and performs MULT/MULTU/DIV/DIVU into architectural HI/LO registers.
- Serves MFHI/MFLO reads and MTHI/MTLO writes.
- Hazard unit stalls the pipeline on busy.

---
 rtl/mdu_pkg.sv | 18 +
 rtl/mdu_negate.sv | 12 +
 rtl/mdu_iterative.sv | 157 +++++++++++++++
 tb/tb_mdu_iterative.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

  localparam logic [1:0] MDU_MULTU = 2'b00;
  localparam logic [1:0] MDU_MULT  = 2'b01;
  localparam logic [1:0] MDU_DIVU  = 2'b10;
  localparam logic [1:0] MDU_DIV   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_t;

  // Quotient reported for a zero divisor.
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_negate.sv
// Combinational conditional two's-complement negation.
module mdu_negate #(
  parameter int W = 64
) (
  input  logic         en,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  assign y = en ? ((~x) + W'(1)) : x;

endmodule

// File: rtl/mdu_iterative.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg;
  logic [1:0]           op_reg;
  logic                 neg_q_reg, neg_r_reg;
  logic [WIDTH-1:0]     dvd_reg;
  logic [WIDTH-1:0]     opnd_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [WIDTH:0]       rem_reg;
  logic [WIDTH-1:0]     hi_reg, lo_reg;
  logic                 done_reg;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 launch, fix_commit;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift, div_next;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign a_neg = op[0] & a[WIDTH-1];
  assign b_neg = op[0] & b[WIDTH-1];

  mdu_negate #(.W(WIDTH)) u_abs_a (.en(a_neg), .x(a), .y(a_mag));
  mdu_negate #(.W(WIDTH)) u_abs_b (.en(b_neg), .x(b), .y(b_mag));

  // Shift-add step: acc holds {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                    (acc_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

  // Restoring step: acc[WIDTH-1:0] shifts dividend bits out and quotient bits in.
  assign div_shift = {rem_reg[WIDTH-1:0], acc_reg[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_reg};
  assign div_next  = div_ge ? (div_shift - {1'b0, opnd_reg}) : div_shift;

  mdu_negate #(.W(2*WIDTH)) u_fix_prod (.en(neg_q_reg), .x(acc_reg), .y(prod_fix));
  mdu_negate #(.W(WIDTH)) u_fix_quo (.en(neg_q_reg), .x(acc_reg[WIDTH-1:0]), .y(quo_fix));
  mdu_negate #(.W(WIDTH)) u_fix_rem (.en(neg_r_reg), .x(rem_reg[WIDTH-1:0]), .y(rem_fix));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    launch     = 1'b0;
    fix_commit = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start && !flush) begin
          launch     = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (flush)                     state_next = S_IDLE;
        else if (cnt_reg == LAST_ITER) state_next = S_FIX;
      end
      S_FIX: begin
        fix_commit = !flush;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      op_reg    <= MDU_MULTU;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      dvd_reg   <= '0;
      opnd_reg  <= '0;
      acc_reg   <= '0;
      rem_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= fix_commit;
      if (launch) begin
        cnt_reg   <= '0;
        op_reg    <= op;
        neg_q_reg <= a_neg ^ b_neg;
        neg_r_reg <= a_neg;
        dvd_reg   <= a;
        rem_reg   <= '0;
        if (op[1]) begin
          opnd_reg <= b_mag;
          acc_reg  <= {{WIDTH{1'b0}}, a_mag};
        end else begin
          opnd_reg <= a_mag;
          acc_reg  <= {{WIDTH{1'b0}}, b_mag};
        end
      end else if (state_reg == S_RUN) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
        if (op_reg[1]) begin
          rem_reg <= div_next;
          acc_reg <= {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-2:0], div_ge};
        end else begin
          acc_reg <= mul_next;
        end
      end

      if (state_reg == S_IDLE) begin
        if (mthi) hi_reg <= a;
        if (mtlo) lo_reg <= a;
      end else if (fix_commit) begin
        if (!op_reg[1]) begin
          hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
          lo_reg <= prod_fix[WIDTH-1:0];
        end else if (opnd_reg == '0) begin
          // Zero divisor: no trap, report the untouched dividend.
          hi_reg <= dvd_reg;
          lo_reg <= WIDTH'(DIV0_LO);
        end else begin
          hi_reg <= rem_fix;
          lo_reg <= quo_fix;
        end
      end
    end
  end

  assign busy = (state_reg != S_IDLE);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_mdu_iterative.sv
// Randomized and directed checks of mdu_iterative against an arithmetic model.
module tb_mdu_iterative;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int e_cyc = 0;

  mdu_iterative #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .mthi(mthi), .mtlo(mtlo),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, truncating signed division.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    res = '0;
    case (o)
      MDU_MULTU: res = {32'b0, x} * {32'b0, y};
      MDU_MULT:  res = sx * sy;
      default: begin
        if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
        else if (o == MDU_DIVU) res = {x % y, x / y};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    e_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic finish_op(input string tag, input logic [63:0] exp);
    int guard = 0;
    logic busy_ok = 1'b1;
    while (!done && guard < 60) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      guard++;
    end
    check({tag, "_lat"}, 64'(cyc - e_cyc), 64'd33);
    check({tag, "_busy_held"}, {63'b0, busy_ok}, 64'd1);
    check({tag, "_hi"}, {32'b0, hi}, {32'b0, exp[63:32]});
    check({tag, "_lo"}, {32'b0, lo}, {32'b0, exp[31:0]});
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", op, a, b, hi, lo, cyc - e_cyc);
    tick();
    check({tag, "_done_pulse"}, {62'b0, done, busy}, 64'd0);
  endtask

  task automatic run_dir(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [63:0] exp);
    launch(o, x, y);
    finish_op(tag, exp);
  endtask

  initial begin
    logic saw_done;
    logic [1:0] ro;
    logic [31:0] rx, ry;

    #2 rst_n = 1'b0;
    tick(); tick();
    check("reset", {30'b0, busy, done, hi}, 64'd0);
    check("reset_lo", {32'b0, lo}, 64'd0);
    rst_n = 1'b1;
    tick();

    run_dir("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_dir("mult_neg", MDU_MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
    run_dir("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_dir("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    run_dir("divu_zero", MDU_DIVU, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF);
    run_dir("div_zero", MDU_DIV, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF);
    run_dir("div_negb", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);

    // Move-to writes while idle.
    a = 32'h0000_1234; mtlo = 1'b1;
    tick();
    mtlo = 1'b0;
    check("mtlo", {hi, lo}, {32'h0000_0064 ^ 32'h0000_0064 ^ 32'h0000_0001, 32'h0000_1234});
    a = 32'h0000_ABCD; mthi = 1'b1; mtlo = 1'b1;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    check("mthi_mtlo", {hi, lo}, {32'h0000_ABCD, 32'h0000_ABCD});

    // start with flush while idle must not launch.
    op = MDU_MULTU; a = 32'd3; b = 32'd4; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("start_flush_idle", {62'b0, busy, done}, 64'd0);
    tick();
    check("start_flush_hold", {hi, lo}, {32'h0000_ABCD, 32'h0000_ABCD});

    // start and mthi ignored while busy.
    launch(MDU_DIVU, 32'd100, 32'd7);
    repeat (4) tick();
    op = MDU_MULTU; a = 32'd55; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0; a = 32'hDEAD_BEEF; mthi = 1'b1;
    tick();
    mthi = 1'b0;
    finish_op("busy_ignore", {32'd2, 32'd14});

    // Flush mid-run: no done, HI/LO untouched.
    launch(MDU_DIVU, 32'd200, 32'd9);
    while (cyc - e_cyc < 10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", {63'b0, busy}, 64'd0);
    saw_done = 1'b0;
    repeat (40) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    check("flush_no_done", {63'b0, saw_done}, 64'd0);
    check("flush_hilo", {hi, lo}, {32'd2, 32'd14});

    // start together with mthi: write happens, result overwrites later.
    op = MDU_DIVU; a = 32'd100; b = 32'd7; mthi = 1'b1; start = 1'b1;
    tick();
    e_cyc = cyc;
    mthi = 1'b0; start = 1'b0;
    check("start_mthi_wr", {31'b0, busy, hi}, {31'b0, 1'b1, 32'd100});
    finish_op("start_mthi", {32'd2, 32'd14});

    // Asynchronous reset mid-operation.
    launch(MDU_MULTU, 32'hFFFF_0000, 32'h0001_2345);
    repeat (19) tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid", {30'b0, busy, done, hi}, 64'd0);
    check("rst_mid_lo", {32'b0, lo}, 64'd0);
    tick();
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    check("rst_no_done", {63'b0, saw_done}, 64'd0);

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       ry = 32'd0;
        1, 2:    ry = 32'($urandom_range(1, 20));
        3:       ry = 32'hFFFF_FFFF - 32'($urandom_range(0, 19));
        default: ry = $urandom;
      endcase
      run_dir("rnd", ro, rx, ry, model(ro, rx, ry));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
